// File: rtl/dram_pkg.sv
// Shared DRAM controller definitions: init/command FSM states and command
// encodings, reused by the init sequencer and the later scheduler.
package dram_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_RST_LOW  = 4'd1,
      ST_CKE_WAIT = 4'd2,
      ST_XPR_WAIT = 4'd3,
      ST_MRS2     = 4'd4,
      ST_MRS3     = 4'd5,
      ST_MRS1     = 4'd6,
      ST_MRS0     = 4'd7,
      ST_ZQCL     = 4'd8,
      ST_DONE     = 4'd9
   } state_t;

   // Command encodings as {ras_n, cas_n, we_n}
   localparam logic [2:0] CMD_NOP   = 3'b111;
   localparam logic [2:0] CMD_MRS   = 3'b000;
   localparam logic [2:0] CMD_ZQCL  = 3'b110;
   localparam logic [2:0] CMD_DESEL = 3'b111;

   localparam logic [15:0] ZQCL_ADDR = 16'h0400;

   // Fixed order of the timed phases; MRS writes go 2,3,1,0.
   function automatic state_t next_step(input state_t s);
      case (s)
         ST_RST_LOW:  return ST_CKE_WAIT;
         ST_CKE_WAIT: return ST_XPR_WAIT;
         ST_XPR_WAIT: return ST_MRS2;
         ST_MRS2:     return ST_MRS3;
         ST_MRS3:     return ST_MRS1;
         ST_MRS1:     return ST_MRS0;
         ST_MRS0:     return ST_ZQCL;
         ST_ZQCL:     return ST_DONE;
         default:     return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/dram_init_seq.sv
// DDR power-up/initialisation sequencer: reset_n low, CKE wait, tXPR,
// four MRS writes (MR2,MR3,MR1,MR0), ZQCL, then DONE. All outputs are
// registered from the next-state decode, so a state's command is on the
// pins in the first cycle that state is registered.
module dram_init_seq
   import dram_pkg::*;
#(
   parameter int unsigned RST_CYC  = 20000,
   parameter int unsigned CKE_CYC  = 50000,
   parameter int unsigned TXPR_CYC = 28,
   parameter int unsigned TMRD_CYC = 4,
   parameter int unsigned TZQ_CYC  = 512,
   parameter logic [15:0] MR0      = 16'h0000,
   parameter logic [15:0] MR1      = 16'h0000,
   parameter logic [15:0] MR2      = 16'h0000,
   parameter logic [15:0] MR3      = 16'h0000
) (
   input  logic        dclk,
   input  logic        reset,
   input  logic        start,
   input  logic        idelayctl_rdy,
   output logic        reset_n,
   output logic        cke,
   output logic [1:0]  s_n,
   output logic        ras_n,
   output logic        cas_n,
   output logic        we_n,
   output logic [2:0]  ba,
   output logic [15:0] addr,
   output logic [1:0]  odt,
   output logic        busy,
   output logic        done
);

   // The two long power-up waits dominate; the short waits are folded in so
   // an unusual parameter set can never overflow the shared counter.
   localparam int unsigned MAX_A   = (RST_CYC  > CKE_CYC)  ? RST_CYC  : CKE_CYC;
   localparam int unsigned MAX_B   = (TXPR_CYC > TZQ_CYC)  ? TXPR_CYC : TZQ_CYC;
   localparam int unsigned MAX_C   = (MAX_B    > TMRD_CYC) ? MAX_B    : TMRD_CYC;
   localparam int unsigned CNT_MAX = (MAX_A    > MAX_C)    ? MAX_A    : MAX_C;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   if (RST_CYC == 0 || CKE_CYC == 0 || TXPR_CYC == 0 ||
       TMRD_CYC == 0 || TZQ_CYC == 0) begin : g_bad_param
      $error("dram_init_seq: timing parameters must be nonzero");
   end

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               entering;

   logic               rn_nx, cke_nx, busy_nx, done_nx;
   logic [1:0]         sn_nx;
   logic [2:0]         cmd_nx, ba_nx;
   logic [15:0]        addr_nx;

   // Counter preload on entry: state lasts exactly N cycles (N-1 down to 0).
   function automatic logic [CNT_W-1:0] wait_len(input state_t s);
      case (s)
         ST_RST_LOW:  return CNT_W'(RST_CYC - 1);
         ST_CKE_WAIT: return CNT_W'(CKE_CYC - 1);
         ST_XPR_WAIT: return CNT_W'(TXPR_CYC - 1);
         ST_MRS2, ST_MRS3,
         ST_MRS1, ST_MRS0: return CNT_W'(TMRD_CYC - 1);
         ST_ZQCL:     return CNT_W'(TZQ_CYC - 1);
         default:     return '0;
      endcase
   endfunction

   // Next state and wait counter.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start && idelayctl_rdy) state_nx = ST_RST_LOW;
         end
         default: begin
            if (cnt == '0) state_nx = next_step(state);
            else           cnt_nx   = cnt - 1'b1;
         end
      endcase
      entering = (state_nx != state);
      if (entering) cnt_nx = wait_len(state_nx);
   end

   // Output decode from the state being entered/held next cycle.
   always_comb begin
      rn_nx   = 1'b1;
      cke_nx  = 1'b1;
      sn_nx   = 2'b00;
      cmd_nx  = CMD_NOP;
      ba_nx   = 3'd0;
      addr_nx = 16'h0000;
      busy_nx = 1'b1;
      done_nx = 1'b0;
      case (state_nx)
         ST_IDLE: begin
            rn_nx   = 1'b0;
            cke_nx  = 1'b0;
            sn_nx   = 2'b11;
            cmd_nx  = CMD_DESEL;
            busy_nx = 1'b0;
         end
         ST_RST_LOW: begin
            rn_nx  = 1'b0;
            cke_nx = 1'b0;
            sn_nx  = 2'b11;
            cmd_nx = CMD_DESEL;
         end
         ST_CKE_WAIT: begin
            cke_nx = 1'b0;
            sn_nx  = 2'b11;
            cmd_nx = CMD_DESEL;
         end
         ST_MRS2: if (entering) begin cmd_nx = CMD_MRS; ba_nx = 3'd2; addr_nx = MR2; end
         ST_MRS3: if (entering) begin cmd_nx = CMD_MRS; ba_nx = 3'd3; addr_nx = MR3; end
         ST_MRS1: if (entering) begin cmd_nx = CMD_MRS; ba_nx = 3'd1; addr_nx = MR1; end
         ST_MRS0: if (entering) begin cmd_nx = CMD_MRS; ba_nx = 3'd0; addr_nx = MR0; end
         ST_ZQCL: if (entering) begin cmd_nx = CMD_ZQCL; addr_nx = ZQCL_ADDR; end
         ST_DONE: begin
            busy_nx = 1'b0;
            done_nx = 1'b1;
         end
         default: ;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge dclk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Registered pin outputs.
   always_ff @(posedge dclk or posedge reset) begin
      if (reset) begin
         reset_n <= 1'b0;
         cke     <= 1'b0;
         s_n     <= 2'b11;
         {ras_n, cas_n, we_n} <= CMD_DESEL;
         ba      <= 3'd0;
         addr    <= 16'h0000;
         odt     <= 2'b00;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         reset_n <= rn_nx;
         cke     <= cke_nx;
         s_n     <= sn_nx;
         {ras_n, cas_n, we_n} <= cmd_nx;
         ba      <= ba_nx;
         addr    <= addr_nx;
         odt     <= 2'b00;
         busy    <= busy_nx;
         done    <= done_nx;
      end
   end

endmodule

// File: tb/tb_dram_init_seq.sv
// Bench for dram_init_seq: a timeline model (cycles since accepted start)
// checked every cycle, plus literal checks on the nominal run's event times.
module tb_dram_init_seq;

   localparam int RST  = 10;
   localparam int CKEW = 20;
   localparam int TXPR = 5;
   localparam int TMRD = 4;
   localparam int TZQ  = 8;
   localparam logic [15:0] M0 = 16'h0120;
   localparam logic [15:0] M1 = 16'h0044;
   localparam logic [15:0] M2 = 16'h0008;
   localparam logic [15:0] M3 = 16'h0000;

   // Event times relative to the first cycle after start is accepted.
   localparam int T_CKE  = RST + CKEW;
   localparam int T_MRS  = T_CKE + TXPR;
   localparam int T_ZQ   = T_MRS + 4 * TMRD;
   localparam int T_DONE = T_ZQ + TZQ;

   localparam logic [29:0] RESET_VEC = {1'b0, 1'b0, 2'b11, 3'b111, 3'd0, 16'h0000, 2'b00, 1'b0, 1'b0};

   logic        dclk = 1'b0;
   logic        reset, start, idelayctl_rdy;
   logic        reset_n, cke, ras_n, cas_n, we_n, busy, done;
   logic [1:0]  s_n, odt;
   logic [2:0]  ba;
   logic [15:0] addr;

   dram_init_seq #(
      .RST_CYC(RST), .CKE_CYC(CKEW), .TXPR_CYC(TXPR), .TMRD_CYC(TMRD), .TZQ_CYC(TZQ),
      .MR0(M0), .MR1(M1), .MR2(M2), .MR3(M3)
   ) dut (
      .dclk(dclk), .reset(reset), .start(start), .idelayctl_rdy(idelayctl_rdy),
      .reset_n(reset_n), .cke(cke), .s_n(s_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
      .ba(ba), .addr(addr), .odt(odt), .busy(busy), .done(done)
   );

   always #5 dclk = ~dclk;

   logic [29:0] dut_vec;
   assign dut_vec = {reset_n, cke, s_n, ras_n, cas_n, we_n, ba, addr, odt, busy, done};

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- model ----------------
   typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
   mode_t mode = M_IDLE;
   int    k = 0;

   // Advance the timeline on every edge the DUT sees.
   always @(posedge dclk or posedge reset) begin
      if (reset) begin
         mode <= M_IDLE;
         k    <= 0;
      end else begin
         case (mode)
            M_IDLE, M_DONE: if (start && idelayctl_rdy) begin mode <= M_RUN; k <= 0; end
            M_RUN: begin
               k <= k + 1;
               if (k + 1 == T_DONE) mode <= M_DONE;
            end
            default: ;
         endcase
      end
   end

   function automatic logic [29:0] exp_out(input mode_t m, input int kk);
      logic       rn, ck, bsy, dn;
      logic [1:0] sn;
      logic [2:0] cmd, b;
      logic [15:0] a;
      rn = 1'b0; ck = 1'b0; sn = 2'b11; cmd = 3'b111; b = 3'd0; a = 16'h0; bsy = 1'b0; dn = 1'b0;
      if (m == M_DONE) begin
         rn = 1'b1; ck = 1'b1; sn = 2'b00; dn = 1'b1;
      end else if (m == M_RUN) begin
         bsy = 1'b1;
         rn  = (kk >= RST);
         ck  = (kk >= T_CKE);
         sn  = (kk >= T_CKE) ? 2'b00 : 2'b11;
         if (kk == T_MRS)            begin cmd = 3'b000; b = 3'd2; a = M2; end
         if (kk == T_MRS + TMRD)     begin cmd = 3'b000; b = 3'd3; a = M3; end
         if (kk == T_MRS + 2 * TMRD) begin cmd = 3'b000; b = 3'd1; a = M1; end
         if (kk == T_MRS + 3 * TMRD) begin cmd = 3'b000; b = 3'd0; a = M0; end
         if (kk == T_ZQ)             begin cmd = 3'b110; a = 16'h0400; end
      end
      return {rn, ck, sn, cmd, b, a, 2'b00, bsy, dn};
   endfunction

   // ---------------- per-cycle compare ----------------
   logic chk_en = 1'b0;

   always @(negedge dclk) begin
      if (chk_en) begin
         chk("cycle_outputs", {2'b00, dut_vec}, {2'b00, exp_out(mode, k)});
         chk("s_n_while_cke_low", {31'b0, (cke == 1'b0 && s_n == 2'b00)}, 32'd0);
         chk("odt_zero", {30'b0, odt}, 32'd0);
      end
   end

   // ---------------- event log for the nominal run ----------------
   logic log_en = 1'b0;
   int   cyc = 0, rn_low_cnt = 0, rn_rise = -1, cke_rise = -1, zq_cyc = -1, done_rise = -1;
   logic rn_prev = 1'b0, cke_prev = 1'b0, done_prev = 1'b0;
   logic [15:0] zq_addr = 16'hffff;
   int          mrs_cyc[$];
   logic [2:0]  mrs_ba[$];
   logic [15:0] mrs_addr[$];

   always @(negedge dclk) begin
      if (log_en) begin
         cyc <= cyc + 1;
         if (busy && !reset_n) rn_low_cnt <= rn_low_cnt + 1;
         if (reset_n && !rn_prev) rn_rise <= cyc;
         if (cke && !cke_prev) cke_rise <= cyc;
         if (done && !done_prev) done_rise <= cyc;
         if (s_n == 2'b00 && {ras_n, cas_n, we_n} == 3'b000) begin
            mrs_cyc.push_back(cyc);
            mrs_ba.push_back(ba);
            mrs_addr.push_back(addr);
         end
         if (s_n == 2'b00 && {ras_n, cas_n, we_n} == 3'b110) begin
            zq_cyc  <= cyc;
            zq_addr <= addr;
         end
      end
      rn_prev   <= reset_n;
      cke_prev  <= cke;
      done_prev <= done;
   end

   // ---------------- stimulus ----------------
   task automatic pulse_start();
      start = 1'b1;
      @(negedge dclk);
      start = 1'b0;
   endtask

   task automatic run_cycles(input int n, input int restart_at);
      for (int i = 0; i < n; i++) begin
         start = (i == restart_at);
         @(negedge dclk);
      end
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; idelayctl_rdy = 1'b0;
      @(negedge dclk);
      chk("reset_state", {2'b00, dut_vec}, {2'b00, RESET_VEC});
      chk_en = 1'b1;
      @(negedge dclk);
      reset = 1'b0;
      @(negedge dclk);

      // Start while IDELAYCTRL not ready is dropped.
      pulse_start();
      run_cycles(3, -1);
      idelayctl_rdy = 1'b1;
      run_cycles(5, -1);
      chk("dropped_start_busy", {31'b0, busy}, 32'd0);
      chk("dropped_start_reset_n", {31'b0, reset_n}, 32'd0);

      // Nominal run with a stray start in CKE_WAIT.
      log_en = 1'b1;
      pulse_start();
      run_cycles(T_DONE + 6, 15);
      log_en = 1'b0;
      chk("reset_n_low_cycles", rn_low_cnt, 32'd10);
      chk("cke_after_reset_n", cke_rise - rn_rise, 32'd20);
      chk("mrs_count", mrs_cyc.size(), 32'd4);
      if (mrs_cyc.size() == 4) begin
         chk("mrs0_ba", {29'b0, mrs_ba[0]}, 32'd2);
         chk("mrs1_ba", {29'b0, mrs_ba[1]}, 32'd3);
         chk("mrs2_ba", {29'b0, mrs_ba[2]}, 32'd1);
         chk("mrs3_ba", {29'b0, mrs_ba[3]}, 32'd0);
         chk("mrs0_addr", {16'b0, mrs_addr[0]}, 32'h0008);
         chk("mrs1_addr", {16'b0, mrs_addr[1]}, 32'h0000);
         chk("mrs2_addr", {16'b0, mrs_addr[2]}, 32'h0044);
         chk("mrs3_addr", {16'b0, mrs_addr[3]}, 32'h0120);
         chk("txpr_gap", mrs_cyc[0] - cke_rise, 32'd5);
         chk("tmrd_gap1", mrs_cyc[1] - mrs_cyc[0], 32'd4);
         chk("tmrd_gap2", mrs_cyc[2] - mrs_cyc[1], 32'd4);
         chk("tmrd_gap3", mrs_cyc[3] - mrs_cyc[2], 32'd4);
         chk("zq_gap", zq_cyc - mrs_cyc[3], 32'd4);
      end
      chk("zq_addr", {16'b0, zq_addr}, 32'h0400);
      chk("done_after_zq", done_rise - zq_cyc, 32'd8);
      chk("done_held", {31'b0, done}, 32'd1);

      // Restart from DONE.
      pulse_start();
      chk("restart_done_low", {31'b0, done}, 32'd0);
      chk("restart_reset_n_low", {31'b0, reset_n}, 32'd0);
      run_cycles(T_DONE + 6, -1);

      // Asynchronous reset during the MRS1 wait.
      pulse_start();
      run_cycles(T_MRS + 2 * TMRD + 1, -1);
      @(posedge dclk);
      #2 reset = 1'b1;
      #1 chk("async_reset", {2'b00, dut_vec}, {2'b00, RESET_VEC});
      @(negedge dclk);
      @(negedge dclk);
      reset = 1'b0;
      @(negedge dclk);
      pulse_start();
      run_cycles(T_DONE + 6, -1);
      chk("post_reset_done", {31'b0, done}, 32'd1);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dram_init_seq.md
DRAM_INIT_SEQ -- requirements
Module: dram_init_seq

Interface
REQ-001 RST_CYC, 20000, dclk cycles reset_n held low after start (200 us at 100 MHz).
REQ-002 CKE_CYC, 50000, dclk cycles from reset_n rising to cke rising (500 us).
REQ-003 TXPR_CYC, 28, dclk cycles from cke rising to first MRS.
REQ-004 TMRD_CYC, 4, dclk cycles from each MRS to the next command (>=1).
REQ-005 TZQ_CYC, 512, dclk cycles from ZQCL to done (>=1).
REQ-006 MR0/MR1/MR2/MR3, 16'h0000 each, addr payloads for the four mode-register writes.
REQ-007 dclk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle request to begin the init sequence.
REQ-010 idelayctl_rdy  in  1  IDELAYCTRL ready; the sequence must not leave IDLE while it is low.
REQ-011 reset_n  out  1  DRAM reset pin, active low.
REQ-012 cke  out  1  clock enable, common to both ranks.
REQ-013 s_n  out  2  chip selects, active low; both ranks are always driven identically.
REQ-014 ras_n, cas_n, we_n  out  1 each  command bits.
REQ-015 ba  out  3  bank address.
REQ-016 addr  out  16  address bus.
REQ-017 odt  out  2  on-die termination; held 0 throughout.
REQ-018 busy  out  1  high from leaving IDLE until DONE is reached.
REQ-019 done  out  1  high in DONE; remains high until the next start or reset.

Function
REQ-020 FSM states: IDLE, RST_LOW, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MRS0, ZQCL, DONE.
REQ-021 IDLE->RST_LOW when start=1 and idelayctl_rdy=1; if start=1 and idelayctl_rdy=0, the start is dropped, not latched.
REQ-022 RST_LOW: reset_n=0 and cke=0 for exactly RST_CYC cycles, then go to CKE_WAIT with reset_n=1.
REQ-023 CKE_WAIT: cke=0 for exactly CKE_CYC cycles, then go to XPR_WAIT with cke=1.
REQ-024 XPR_WAIT: NOP for TXPR_CYC cycles, then go to MRS2.
REQ-025 MRSn: MRS command for one cycle, with s_n=00, ras_n=cas_n=we_n=0, ba=n and addr=MRn; then NOP for TMRD_CYC-1 cycles; then go to the next state in the order 2,3,1,0.
REQ-026 ZQCL: one cycle with s_n=00, ras_n=1, cas_n=1, we_n=0, addr=16'h0400 and ba=0; then NOP for TZQ_CYC-1 cycles; then go to DONE.
REQ-027 NOP encoding: s_n=00, ras_n=cas_n=we_n=1, ba=0, addr=0.
REQ-028 In IDLE, RST_LOW and CKE_WAIT, command outputs are deselected: s_n=11, ras_n=cas_n=we_n=1.
REQ-029 All outputs are registered; the command for a state appears in the first dclk in which that state is registered.
REQ-030 Waits use a single down-counter sized for max(RST_CYC, CKE_CYC).
REQ-031 A parameter value of 0 is illegal and shall be rejected by an elaboration-time assertion.
REQ-032 start while busy=1 is ignored.
REQ-033 start in DONE (with idelayctl_rdy=1) restarts at RST_LOW; done falls in the same cycle that busy rises.
REQ-034 In DONE, cke=1, reset_n=1 and NOP is driven.

Reset
REQ-035 Asserting reset at any time, including mid-sequence, forces IDLE asynchronously.
REQ-036 Reset values: reset_n=0, cke=0, s_n=11, ras_n=cas_n=we_n=1, ba=0, addr=0, odt=00, busy=0, done=0, counter=0.
REQ-037 Deassertion of reset is synchronized to dclk by the integrator; the block itself adds no synchronizer.

Structure
REQ-038 Package dram_pkg holds the state enum typedef and the command-encoding constants (NOP, MRS, ZQCL, DESEL as {ras_n,cas_n,we_n}), for reuse by the later refresh/read-write scheduler.
REQ-039 No sub-module is needed: the FSM and counter form one flat module.

Verification (RST_CYC=10, CKE_CYC=20, TXPR_CYC=5, TMRD_CYC=4, TZQ_CYC=8, MR0..3=16'h0120, 16'h0044, 16'h0008, 16'h0000)
REQ-040 Nominal run: start with idelayctl_rdy=1 -> reset_n low for 10 cycles, cke rises 20 cycles later, MRS with ba=2,3,1,0 spaced 4 cycles apart carrying the exact MR values, ZQCL with addr=16'h0400, done rises 8 cycles after ZQCL.
REQ-041 Pulse start with idelayctl_rdy=0, then raise idelayctl_rdy -> the block stays in IDLE with busy=0 until a new start arrives.
REQ-042 Pulse start again during CKE_WAIT -> no restart and no change in timing.
REQ-043 Assert reset during MRS1's wait -> all outputs take reset values immediately, with no clock edge needed; after release a new start produces a full, correct sequence.
REQ-044 Pulse start while done=1 -> done falls, reset_n falls in the same cycle, and the full sequence repeats.
REQ-045 Cycle-by-cycle check of the whole run: s_n is never 00 while cke=0, and odt is always 00.
